// File: rtl/sprite_compositor.sv
// N-sprite overlay stage: frame-committed sprite registers, 1-cycle ROM fetch,
// priority compositing and sticky collision flags with interrupt.
module sprite_compositor #(
    parameter int NSPR    = 4,
    parameter int SZ_LOG2 = 5,
    parameter int CW      = 4,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int AW      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic                      read,
    input  logic [AW-1:0]             address,
    input  logic [15:0]               writedata,
    output logic [15:0]               readdata,
    input  logic                      pix_valid,
    input  logic [XW-1:0]             pix_x,
    input  logic [YW-1:0]             pix_y,
    input  logic [CW-1:0]             bg_color,
    input  logic                      frame_start,
    output logic [NSPR*5-1:0]         rom_img,
    output logic [NSPR*2*SZ_LOG2-1:0] rom_addr,
    input  logic [NSPR*CW-1:0]        rom_data,
    output logic                      out_valid,
    output logic [CW-1:0]             out_color,
    output logic                      irq
);
    localparam int SZ = 1 << SZ_LOG2;
    localparam int AL = 2 * SZ_LOG2;
    localparam logic [AW-1:0] COLL_A = AW'(4 * NSPR);
    localparam logic [AW-1:0] IEN_A  = AW'(4 * NSPR + 1);

    logic [XW-1:0] sh_x    [NSPR];
    logic [YW-1:0] sh_y    [NSPR];
    logic [4:0]    sh_img  [NSPR];
    logic [1:0]    sh_ctrl [NSPR];
    logic [XW-1:0] ac_x    [NSPR];
    logic [YW-1:0] ac_y    [NSPR];
    logic [4:0]    ac_img  [NSPR];
    logic [1:0]    ac_ctrl [NSPR];

    logic [NSPR-1:0] coll;
    logic [NSPR-1:0] irq_en;
    logic [NSPR-1:0] hit;
    logic [NSPR-1:0] hit_q;
    logic [NSPR-1:0] opaque;
    logic [NSPR-1:0] coll_set;
    logic [NSPR-1:0] coll_clr;
    logic [CW-1:0]   bg_q;
    logic [CW-1:0]   pick;
    logic [15:0]     rdv;
    logic            valid_q;
    logic            multi;
    logic            wr;
    logic            rd;
    logic [XW:0]     px;
    logic [YW:0]     py;
    logic            unused_ok;

    assign wr = chipselect & write;
    assign rd = chipselect & read;
    assign px = {1'b0, pix_x};
    assign py = {1'b0, pix_y};
    assign unused_ok = ^writedata;

    // Shadow written by the bus; active takes the pre-write shadow on frame_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSPR; i++) begin
                sh_x[i]    <= '0;
                sh_y[i]    <= '0;
                sh_img[i]  <= '0;
                sh_ctrl[i] <= '0;
                ac_x[i]    <= '0;
                ac_y[i]    <= '0;
                ac_img[i]  <= '0;
                ac_ctrl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (wr && address == AW'(4 * i))
                    sh_x[i] <= writedata[XW-1:0];
                if (wr && address == AW'(4 * i + 1))
                    sh_y[i] <= writedata[YW-1:0];
                if (wr && address == AW'(4 * i + 2))
                    sh_img[i] <= writedata[4:0];
                if (wr && address == AW'(4 * i + 3))
                    sh_ctrl[i] <= writedata[1:0];
                if (frame_start) begin
                    ac_x[i]    <= sh_x[i];
                    ac_y[i]    <= sh_y[i];
                    ac_img[i]  <= sh_img[i];
                    ac_ctrl[i] <= sh_ctrl[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_spr
        logic [XW:0]         sx;
        logic [YW:0]         sy;
        logic [SZ_LOG2-1:0]  dx_raw;
        logic [SZ_LOG2-1:0]  dx;
        logic [SZ_LOG2-1:0]  dy;

        assign sx = {1'b0, ac_x[g]};
        assign sy = {1'b0, ac_y[g]};
        assign hit[g] = ac_ctrl[g][0]
                     && px >= sx && px < sx + (XW+1)'(SZ)
                     && py >= sy && py < sy + (YW+1)'(SZ);
        assign dx_raw = SZ_LOG2'(pix_x - ac_x[g]);
        assign dy     = SZ_LOG2'(pix_y - ac_y[g]);
        // Bitwise inversion equals SZ-1-dx for an SZ_LOG2-bit offset.
        assign dx = ac_ctrl[g][1] ? ~dx_raw : dx_raw;
        assign rom_addr[g*AL +: AL] = {dy, dx};
        assign rom_img[g*5 +: 5]    = ac_img[g];
        assign opaque[g] = hit_q[g] && (rom_data[g*CW +: CW] != '0);
    end

    always_comb begin
        pick = bg_q;
        for (int i = NSPR - 1; i >= 0; i--)
            if (opaque[i]) pick = rom_data[i*CW +: CW];
    end

    assign multi    = |(opaque & (opaque - NSPR'(1)));
    assign coll_set = (valid_q && multi) ? opaque : '0;
    assign coll_clr = (wr && address == COLL_A) ? writedata[NSPR-1:0] : '0;
    assign irq      = |(coll & irq_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q     <= '0;
            bg_q      <= '0;
            valid_q   <= 1'b0;
            out_valid <= 1'b0;
            out_color <= '0;
        end else begin
            hit_q     <= hit;
            bg_q      <= bg_color;
            valid_q   <= pix_valid;
            out_valid <= valid_q;
            out_color <= pick;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll   <= '0;
            irq_en <= '0;
        end else begin
            coll <= (coll & ~coll_clr) | coll_set;
            if (wr && address == IEN_A)
                irq_en <= writedata[NSPR-1:0];
        end
    end

    always_comb begin
        rdv = '0;
        for (int i = 0; i < NSPR; i++) begin
            if (address == AW'(4 * i))     rdv = 16'(sh_x[i]);
            if (address == AW'(4 * i + 1)) rdv = 16'(sh_y[i]);
            if (address == AW'(4 * i + 2)) rdv = 16'(sh_img[i]);
            if (address == AW'(4 * i + 3)) rdv = 16'(sh_ctrl[i]);
        end
        if (address == COLL_A) rdv = 16'(coll);
        if (address == IEN_A)  rdv = 16'(irq_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   readdata <= '0;
        else if (rd) readdata <= rdv;
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: vector table for pixel/ROM-address
// checks plus hand sequences for frame commit, collisions and reset.
module tb_sprite_compositor;
    logic        clk = 0;
    logic        reset = 1;
    logic        chipselect = 0, write = 0, read = 0;
    logic [5:0]  address = 0;
    logic [15:0] writedata = 0;
    logic [15:0] readdata;
    logic        pix_valid = 0;
    logic [9:0]  pix_x = 0, pix_y = 0;
    logic [3:0]  bg_color = 0;
    logic        frame_start = 0;
    logic [19:0] rom_img;
    logic [39:0] rom_addr;
    logic [15:0] rom_data = 0;
    logic        out_valid;
    logic [3:0]  out_color;
    logic        irq;

    logic [3:0]  rom_val [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    int cmp = 0;
    int bad = 0;

    typedef struct {
        int x; int y; int bg; int color; int addr0; bit chk;
    } vec_t;
    vec_t vecs [11];

    sprite_compositor dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .bg_color(bg_color), .frame_start(frame_start),
        .rom_img(rom_img), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_color(out_color), .irq(irq)
    );

    always #10 clk = ~clk;

    // 1-cycle ROM: each sprite's image is a single solid colour.
    always @(posedge clk)
        for (int i = 0; i < 4; i++) rom_data[i*4 +: 4] <= rom_val[i];

    task automatic check(input string nm, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wreg(input int a, input int d);
        @(negedge clk);
        chipselect = 1; write = 1; address = 6'(a); writedata = 16'(d);
        @(negedge clk);
        chipselect = 0; write = 0;
    endtask

    task automatic rreg(input int a, output int d);
        @(negedge clk);
        chipselect = 1; read = 1; address = 6'(a);
        @(negedge clk);
        chipselect = 0; read = 0;
        d = int'(readdata);
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
    endtask

    task automatic pixel(input string nm, input int x, input int y,
                         input int bg, input int exp);
        @(negedge clk);
        pix_x = 10'(x); pix_y = 10'(y); bg_color = 4'(bg); pix_valid = 1;
        @(negedge clk);
        pix_valid = 0;
        @(negedge clk);
        check({nm, "_valid"}, int'(out_valid), 1);
        check({nm, "_color"}, int'(out_color), exp);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            pix_x = 10'(vecs[k].x); pix_y = 10'(vecs[k].y);
            bg_color = 4'(vecs[k].bg); pix_valid = 1;
            #1;
            if (vecs[k].chk)
                check($sformatf("vec%0d_addr0", k), int'(rom_addr[9:0]), vecs[k].addr0);
            @(negedge clk);
            pix_valid = 0;
            @(negedge clk);
            check($sformatf("vec%0d_valid", k), int'(out_valid), 1);
            check($sformatf("vec%0d_color", k), int'(out_color), vecs[k].color);
        end
    endtask

    initial begin
        int d;
        bit pat [8] = '{1, 1, 0, 1, 1, 1, 0, 1};

        vecs[0]  = '{100, 50, 2, 5, 0, 1};
        vecs[1]  = '{131, 81, 2, 5, 1023, 1};
        vecs[2]  = '{132, 50, 2, 2, 0, 1};
        vecs[3]  = '{99, 50, 2, 2, 31, 1};
        vecs[4]  = '{115, 60, 2, 5, 335, 1};
        vecs[5]  = '{100, 82, 2, 2, 0, 1};
        vecs[6]  = '{0, 50, 2, 3, 31, 1};
        vecs[7]  = '{31, 51, 2, 3, 32, 1};
        vecs[8]  = '{639, 50, 2, 3, 9, 1};
        vecs[9]  = '{0, 50, 2, 2, 0, 0};
        vecs[10] = '{635, 55, 2, 3, 165, 1};

        // Reset state
        #5;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_color", int'(out_color), 0);
        check("rst_readdata", int'(readdata), 0);
        check("rst_irq", int'(irq), 0);
        @(negedge clk);
        reset = 0;

        // Background stream with 2-clock latency
        bg_color = 2;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                check($sformatf("bg_valid%0d", t), int'(out_valid), int'(pat[t-2]));
                if (pat[t-2]) check($sformatf("bg_color%0d", t), int'(out_color), 2);
                check($sformatf("bg_irq%0d", t), int'(irq), 0);
            end
            pix_valid = (t < 8) ? pat[t] : 1'b0;
            pix_x = 10'(t * 7); pix_y = 10'(t);
        end

        // Single sprite placement and ROM addressing
        rom_val[0] = 5;
        wreg(0, 100); wreg(1, 50); wreg(2, 3); wreg(3, 1);
        frame();
        check("img0", int'(rom_img[4:0]), 3);
        apply(0, 5);
        rreg(0, d); check("rd_x0", d, 100);
        rreg(3, d); check("rd_ctrl0", d, 1);
        rreg(30, d); check("rd_unmapped", d, 0);

        // Frame-committed position update
        wreg(0, 200);
        pixel("mid_old", 100, 50, 2, 5);
        pixel("mid_new", 200, 50, 2, 2);
        frame();
        pixel("f1_new", 200, 50, 2, 5);
        pixel("f1_old", 100, 50, 2, 2);
        @(negedge clk);
        frame_start = 1; chipselect = 1; write = 1; address = 0; writedata = 300;
        @(negedge clk);
        frame_start = 0; chipselect = 0; write = 0;
        pixel("coin_act", 200, 50, 2, 5);
        pixel("coin_shd", 300, 50, 2, 2);
        frame();
        pixel("f2_new", 300, 50, 2, 5);
        pixel("f2_old", 200, 50, 2, 2);

        // Overlap, priority, collision and irq
        rom_val[0] = 3; rom_val[1] = 6;
        wreg(4, 310); wreg(5, 60); wreg(7, 1);
        frame();
        pixel("only0", 305, 55, 2, 3);
        rreg(16, d); check("coll_none", d, 0);
        pixel("only1", 335, 85, 2, 6);
        pixel("overlap", 315, 65, 2, 3);
        rreg(16, d); check("coll_both", d, 3);
        check("irq_off", int'(irq), 0);
        wreg(17, 1);
        check("irq_on", int'(irq), 1);
        rreg(17, d); check("rd_irq_en", d, 1);
        wreg(16, 1);
        rreg(16, d); check("coll_w1c", d, 2);
        check("irq_drop", int'(irq), 0);
        wreg(16, 2);
        rreg(16, d); check("coll_clr", d, 0);

        // Horizontal flip at left edge
        wreg(0, 0); wreg(1, 50); wreg(3, 3);
        frame();
        apply(6, 7);

        // Right-edge clipping and transparent overlap
        rom_val[1] = 0;
        wreg(0, 630); wreg(3, 1); wreg(4, 630); wreg(5, 50);
        frame();
        apply(8, 10);
        rreg(16, d); check("coll_transp", d, 0);

        // Asynchronous reset mid-line
        rom_val[1] = 6;
        pixel("pre_rst", 635, 55, 2, 3);
        check("pre_rst_irq", int'(irq), 1);
        @(negedge clk);
        pix_x = 635; pix_y = 55; bg_color = 2; pix_valid = 1;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_color", int'(out_color), 0);
        check("rst_mid_irq", int'(irq), 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_color", int'(out_color), 2);
        pix_valid = 0;
        rreg(0, d); check("post_rst_x0", d, 0);
        rreg(16, d); check("post_rst_coll", d, 0);
        rreg(17, d); check("post_rst_ien", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
